host_cmd_master: RTL and testbench

Host-side initiator for the digital core's command/response interface. It latches a 16-bit host command, presents it with a `cmd_rdy`/`clr_cmd_rdy` handshake, then collects the expected number of 8-bit response bytes via `send_resp`/`resp_sent`, forwarding each byte upstream. It sits between the host link logic (or a bench stimulus block) and the digital core, acting as the opposite end of the core's command interpreter.

---
 rtl/host_cmd_master.sv | 159 +++++++++++++++
 tb/tb_host_cmd_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_master.sv
// Host-side command initiator: issues one 16-bit command to the core, then
// collects the expected number of response bytes and forwards each upstream.
module host_cmd_master #(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned LOG2    = 9,
    parameter int unsigned TMO_W   = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [15:0]     host_cmd_i,
    input  logic            host_go_i,
    output logic            busy_o,
    output logic [15:0]     cmd_o,
    output logic            cmd_rdy_o,
    input  logic            clr_cmd_rdy_i,
    input  logic [7:0]      resp_i,
    input  logic            send_resp_i,
    output logic            resp_sent_o,
    output logic [7:0]      rx_byte_o,
    output logic            rx_vld_o,
    output logic [LOG2:0]   byte_cnt_o,
    output logic            done_o,
    output logic            err_timeout_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitResp, StAck} state_e;

    localparam logic [LOG2:0]    DumpCnt = (LOG2 + 1)'(ENTRIES);
    localparam logic [LOG2:0]    OneCnt  = (LOG2 + 1)'(1);
    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT - 1);

    state_e           state_q;
    logic [15:0]      cmd_q;
    logic             cmd_rdy_q;
    logic             busy_q;
    logic             resp_sent_q;
    logic [7:0]       rx_byte_q;
    logic             rx_vld_q;
    logic [LOG2:0]    byte_cnt_q;
    logic [LOG2:0]    exp_cnt_q;
    logic             done_q;
    logic             err_q;
    logic [TMO_W-1:0] tmo_q;

    logic             tmo_hit;
    logic [LOG2:0]    cnt_inc;
    logic [LOG2:0]    exp_sel;

    // Timeout compare, saturating byte increment and expected count for a new command
    always_comb begin
        tmo_hit = (tmo_q == TmoLast);
        cnt_inc = (byte_cnt_q == exp_cnt_q) ? byte_cnt_q : byte_cnt_q + 1'b1;
        exp_sel = (host_cmd_i[15:14] == 2'b10) ? DumpCnt : OneCnt;
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            busy_q      <= 1'b0;
            resp_sent_q <= 1'b0;
            rx_byte_q   <= '0;
            rx_vld_q    <= 1'b0;
            byte_cnt_q  <= '0;
            exp_cnt_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            // Pulse outputs default low
            rx_vld_q    <= 1'b0;
            resp_sent_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (host_go_i) begin
                        cmd_q      <= host_cmd_i;
                        exp_cnt_q  <= exp_sel;
                        byte_cnt_q <= '0;
                        err_q      <= 1'b0;
                        cmd_rdy_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        tmo_q      <= '0;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    if (clr_cmd_rdy_i) begin
                        cmd_rdy_q <= 1'b0;
                        tmo_q     <= '0;
                        // Core may hand back its first byte in the acceptance cycle
                        if (send_resp_i) begin
                            rx_byte_q   <= resp_i;
                            rx_vld_q    <= 1'b1;
                            resp_sent_q <= 1'b1;
                            byte_cnt_q  <= cnt_inc;
                            state_q     <= StAck;
                        end else begin
                            state_q <= StWaitResp;
                        end
                    end else if (tmo_hit) begin
                        err_q     <= 1'b1;
                        done_q    <= 1'b1;
                        cmd_rdy_q <= 1'b0;
                        busy_q    <= 1'b0;
                        tmo_q     <= '0;
                        state_q   <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StWaitResp: begin
                    if (send_resp_i) begin
                        rx_byte_q   <= resp_i;
                        rx_vld_q    <= 1'b1;
                        resp_sent_q <= 1'b1;
                        byte_cnt_q  <= cnt_inc;
                        tmo_q       <= '0;
                        state_q     <= StAck;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StAck: begin
                    // send_resp is ignored here; resp_sent is high for this one cycle
                    tmo_q <= '0;
                    if (byte_cnt_q == exp_cnt_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StWaitResp;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign cmd_o         = cmd_q;
    assign cmd_rdy_o     = cmd_rdy_q;
    assign resp_sent_o   = resp_sent_q;
    assign rx_byte_o     = rx_byte_q;
    assign rx_vld_o      = rx_vld_q;
    assign byte_cnt_o    = byte_cnt_q;
    assign done_o        = done_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_host_cmd_master.sv
// Scoreboard bench for host_cmd_master: stimulus pushes expected bytes and
// completions; a negedge monitor pops and compares when the DUT presents them.
module tb_host_cmd_master;

    localparam int unsigned LOG2 = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [15:0]     host_cmd_i = '0;
    logic            host_go_i = 1'b0;
    logic            busy_o;
    logic [15:0]     cmd_o;
    logic            cmd_rdy_o;
    logic            clr_cmd_rdy_i = 1'b0;
    logic [7:0]      resp_i = '0;
    logic            send_resp_i = 1'b0;
    logic            resp_sent_o;
    logic [7:0]      rx_byte_o;
    logic            rx_vld_o;
    logic [LOG2:0]   byte_cnt_o;
    logic            done_o;
    logic            err_timeout_o;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int exp_done_n = 0;
    int exp_rx_q[$];    // {cnt, byte}
    int exp_done_q[$];  // {err, cnt}
    logic prev_rs = 1'b0;

    host_cmd_master #(
        .ENTRIES(384),
        .LOG2   (LOG2),
        .TMO_W  (16),
        .TIMEOUT(20)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .host_cmd_i   (host_cmd_i),
        .host_go_i    (host_go_i),
        .busy_o       (busy_o),
        .cmd_o        (cmd_o),
        .cmd_rdy_o    (cmd_rdy_o),
        .clr_cmd_rdy_i(clr_cmd_rdy_i),
        .resp_i       (resp_i),
        .send_resp_i  (send_resp_i),
        .resp_sent_o  (resp_sent_o),
        .rx_byte_o    (rx_byte_o),
        .rx_vld_o     (rx_vld_o),
        .byte_cnt_o   (byte_cnt_o),
        .done_o       (done_o),
        .err_timeout_o(err_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] c);
        host_cmd_i = c;
        host_go_i  = 1'b1;
        tick();
        host_go_i  = 1'b0;
        host_cmd_i = '0;
        chk("cmd_latched", int'(cmd_o), int'(c));
        chk("cmd_rdy_rise", int'(cmd_rdy_o), 1);
        chk("busy_rise", int'(busy_o), 1);
    endtask

    task automatic accept(input int dly);
        repeat (dly) tick();
        clr_cmd_rdy_i = 1'b1;
        tick();
        clr_cmd_rdy_i = 1'b0;
        chk("cmd_rdy_fall", int'(cmd_rdy_o), 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int cnt);
        exp_rx_q.push_back((cnt << 8) | int'(b));
        resp_i      = b;
        send_resp_i = 1'b1;
        tick();
        send_resp_i = 1'b0;
        tick();
    endtask

    task automatic expect_done(input int err, input int cnt);
        exp_done_q.push_back((err << 16) | cnt);
        exp_done_n++;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 8 && done_cnt < exp_done_n; i++) tick();
        chk("done_seen", done_cnt, exp_done_n);
    endtask

    // Monitor: compare captured bytes and completions against the scoreboard
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            if (resp_sent_o) chk("resp_sent_single", int'(prev_rs), 0);
            if (resp_sent_o) chk("rx_vld_with_resp_sent", int'(rx_vld_o), 1);
            if (rx_vld_o) begin
                chk("resp_sent_with_rx_vld", int'(resp_sent_o), 1);
                if (exp_rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rx: got %0h expected none", rx_byte_o);
                end else begin
                    e = exp_rx_q.pop_front();
                    chk("rx_byte", int'(rx_byte_o), e & 255);
                    chk("rx_byte_cnt", int'(byte_cnt_o), e >> 8);
                end
            end
            if (done_o) begin
                done_cnt++;
                chk("done_busy_low", int'(busy_o), 0);
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end else begin
                    e = exp_done_q.pop_front();
                    chk("done_err", int'(err_timeout_o), e >> 16);
                    chk("done_cnt", int'(byte_cnt_o), e & 16'hFFFF);
                end
            end
        end
        prev_rs <= resp_sent_o;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd"}, int'(cmd_o), 0);
        chk({tag, "_cmd_rdy"}, int'(cmd_rdy_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_resp_sent"}, int'(resp_sent_o), 0);
        chk({tag, "_rx_byte"}, int'(rx_byte_o), 0);
        chk({tag, "_rx_vld"}, int'(rx_vld_o), 0);
        chk({tag, "_byte_cnt"}, int'(byte_cnt_o), 0);
        chk({tag, "_done"}, int'(done_o), 0);
        chk({tag, "_err"}, int'(err_timeout_o), 0);
    endtask

    initial begin
        int k;
        // Reset state
        tick();
        chk_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Read-register: accept 3 cycles after go, single byte 5A
        issue(16'h0800);
        expect_done(0, 1);
        accept(2);
        send_byte(8'h5A, 1);
        wait_done();

        // Dump of 384 bytes with a second host_go in the middle
        issue(16'h8100);
        expect_done(0, 384);
        accept(1);
        for (int i = 0; i < 384; i++) begin
            if (i == 100) begin
                host_cmd_i = 16'hFFFF;
                host_go_i  = 1'b1;
                tick();
                host_go_i  = 1'b0;
                host_cmd_i = '0;
                chk("busy_guard_cmd", int'(cmd_o), 16'h8100);
                chk("busy_guard_busy", int'(busy_o), 1);
            end
            send_byte(8'(i), i + 1);
        end
        wait_done();
        chk("dump_cmd_held", int'(cmd_o), 16'h8100);

        // Same-cycle accept and first byte
        issue(16'h4000);
        expect_done(0, 1);
        exp_rx_q.push_back((1 << 8) | 8'hA5);
        clr_cmd_rdy_i = 1'b1;
        send_resp_i   = 1'b1;
        resp_i        = 8'hA5;
        tick();
        clr_cmd_rdy_i = 1'b0;
        send_resp_i   = 1'b0;
        chk("same_cycle_cmd_rdy", int'(cmd_rdy_o), 0);
        chk("same_cycle_resp_sent", int'(resp_sent_o), 1);
        tick();
        wait_done();

        // Timeout: command never accepted
        issue(16'h0000);
        expect_done(1, 0);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done_o) begin
                k = i;
                break;
            end
        end
        chk("tmo_latency", k, 20);
        chk("tmo_err", int'(err_timeout_o), 1);
        chk("tmo_cmd_rdy", int'(cmd_rdy_o), 0);
        wait_done();
        chk("tmo_err_sticky", int'(err_timeout_o), 1);
        issue(16'h0400);
        chk("tmo_err_cleared", int'(err_timeout_o), 0);
        expect_done(0, 1);
        accept(0);
        send_byte(8'h11, 1);
        wait_done();

        // Reset in the middle of a dump
        issue(16'h8100);
        accept(1);
        for (int i = 0; i < 10; i++) send_byte(8'(i + 8'h30), i + 1);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        chk("midreset_rx_drained", exp_rx_q.size(), 0);
        exp_done_q.delete();
        tick();
        rst = 1'b0;
        tick();
        issue(16'h0001);
        expect_done(0, 1);
        accept(1);
        send_byte(8'h3C, 1);
        wait_done();

        tick();
        chk("final_rx_queue_empty", exp_rx_q.size(), 0);
        chk("final_done_queue_empty", exp_done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
